mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the MDR/MAR datapath.
- Accepts level read/write requests, inserts programmable wait states and performs the access on an internal synchronous RAM array.
- Read path: drives read data, then a separate strobe (readEn) that the MDR uses as its latch edge.
- Write path: captures MDR write data (dToWriteOut) and acknowledges with writeDone.

Parameters:
- AWIDTH, 8, array index width; array depth = 2^AWIDTH words of 16 bits.
- WAIT_CYCLES, 2, wait states inserted between acceptance and array access; legal range 0..15.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- addr  input  16  word address from MAR, sampled at acceptance
- dWriteIn  input  16  write data from MDR dToWriteOut, sampled at acceptance
- memRead  input  1  level read request
- memWrite  input  1  level write request
- dReadOut  output  16  read data to MDR dReadIn, registered
- readEn  output  1  one-cycle read strobe, registered; MDR latches on its rising edge
- writeDone  output  1  one-cycle write acknowledge, registered
- busy  output  1  high while a transaction is in flight

Behaviour:
- Reset value of every output: dReadOut = 0, readEn = 0, writeDone = 0, busy = 0. State goes to IDLE; wait counter = 0.
- Reset does not clear the RAM array; contents after power-up are undefined.
- States: IDLE, WAIT, ACCESS, RESP, DONE.
- IDLE: at the edge where memRead or memWrite is high (accept edge E0):
  - latch addr, dWriteIn and op; set busy = 1.
  - go to WAIT with count = WAIT_CYCLES, or straight to ACCESS if WAIT_CYCLES = 0.
  - If memRead and memWrite are both high, the read wins and the write request is ignored.
- WAIT: decrement count each edge; at count = 1 go to ACCESS.
- ACCESS (edge E0+W+1):
  - read: dReadOut <= mem[latched addr].
  - write: mem[latched addr] <= latched data.
  - go to RESP.
- RESP (edge E0+W+2): readEn <= 1 for a read, or writeDone <= 1 for a write; go to DONE. dReadOut is stable one full cycle before readEn rises.
- DONE (edge E0+W+3): readEn and writeDone <= 0, busy <= 0; go to IDLE.
- Earliest next acceptance is edge E0+W+4.
- Requests are sampled only in IDLE. Request changes during WAIT/ACCESS/RESP/DONE are ignored. A request still high on return to IDLE starts a new transaction (back-to-back operation).
- dReadOut holds its last read value until the next read completes ACCESS; writes never alter it.
- Address mapping: the array index is addr[AWIDTH-1:0], so the upper address bits wrap (behaviour without the optional feature).
- Reset asserted in any state returns to IDLE at that edge. A write is aborted with no array update if reset is high at the ACCESS edge. No strobe is emitted for the aborted transaction.
- WAIT_CYCLES above 15 is a configuration error; it is checked by elaboration assertion.

Optional Feature:
- Macro: MEM_BOUNDS_CHECK_EN.
- When defined:
  - adds output memErr (1 bit, reset 0).
  - any accepted request with addr[15:AWIDTH] != 0 runs the normal state sequence, but in ACCESS performs no array write and loads dReadOut = 0.
  - memErr pulses high in RESP alongside readEn or writeDone.
- When undefined: no memErr port; upper address bits are ignored (wrap-around).

Test Plan:
- Reset check: assert reset two cycles mid-WAIT of a write to 0x05 -> all outputs 0, state IDLE, later read of 0x05 returns its prior value (write aborted).
- Basic write then read, W=2: write 0xBEEF to 0x12, writeDone pulses at E0+4; read 0x12 -> dReadOut = 0xBEEF at E0+3, readEn high only during the cycle after E0+4, busy low after E0+5.
- Zero wait states, W=0: write 0x1234 to 0x00, then read 0x00 -> readEn one cycle after dReadOut update, total read latency 3 edges, value 0x1234.
- Simultaneous request: memRead = memWrite = 1, addr 0x20 holding 0x00AA, dWriteIn 0x5555 -> read performed (dReadOut = 0x00AA), mem[0x20] unchanged, no writeDone.
- Back-to-back holding: memRead held high for 12 cycles at W=1 -> readEn pulses exactly every 5 cycles; addr change during WAIT has no effect on the current transaction.
- Bounds: read addr 0x0112 with AWIDTH=8.
  - without MEM_BOUNDS_CHECK_EN: returns mem[0x12].
  - with it: dReadOut = 0, memErr pulses with readEn; write to 0x0112 leaves mem[0x12] unchanged.

Source files
------------

// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bundle between the MDR/MAR datapath and mem_responder.
//
// Signals
//   addr      16  word address from MAR
//   dWriteIn  16  write data from MDR dToWriteOut
//   memRead    1  level read request
//   memWrite   1  level write request
//   dReadOut  16  registered read data to MDR dReadIn
//   readEn     1  one-cycle read strobe; the MDR latches on its rising edge
//   writeDone  1  one-cycle write acknowledge
//   busy       1  high while a transaction is in flight
//   memErr     1  out-of-range access flag, present only with MEM_BOUNDS_CHECK_EN
//
// Modports: master = datapath side, slave = responder side.
// Optional feature macro: MEM_BOUNDS_CHECK_EN.

interface mem_responder_if;
    logic [15:0] addr;
    logic [15:0] dWriteIn;
    logic        memRead;
    logic        memWrite;
    logic [15:0] dReadOut;
    logic        readEn;
    logic        writeDone;
    logic        busy;
`ifdef MEM_BOUNDS_CHECK_EN
    logic        memErr;
`endif

    modport master (
        output addr, dWriteIn, memRead, memWrite,
        input  dReadOut, readEn, writeDone, busy
`ifdef MEM_BOUNDS_CHECK_EN
        , input memErr
`endif
    );

    modport slave (
        input  addr, dWriteIn, memRead, memWrite,
        output dReadOut, readEn, writeDone, busy
`ifdef MEM_BOUNDS_CHECK_EN
        , output memErr
`endif
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the MDR/MAR datapath.
//
// Accepts level read/write requests while idle, waits WAIT_CYCLES states, then accesses an
// internal 2^AWIDTH x 16 synchronous array. Reads update dReadOut one cycle before the readEn
// strobe; writes are acknowledged with a writeDone pulse.
//
// Ports
//   clk    system clock, rising edge
//   reset  synchronous, active-high reset (does not clear the array)
//   bus    mem_responder_if.slave: addr, dWriteIn, memRead, memWrite in;
//          dReadOut, readEn, writeDone, busy (and memErr) out
//
// Parameters
//   AWIDTH       array index width (1..15); the index is addr[AWIDTH-1:0]
//   WAIT_CYCLES  wait states between acceptance and array access (0..15)
//
// Optional feature macro: MEM_BOUNDS_CHECK_EN. When defined, a request with any address bit
// above AWIDTH set still runs the full sequence but writes nothing, reads back 0 and raises
// memErr alongside the response strobe. When undefined the upper address bits wrap.

module mem_responder #(
    parameter int unsigned AWIDTH      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic           clk,
    input logic           reset,
    mem_responder_if.slave bus
);

    localparam int unsigned Depth = 1 << AWIDTH;

    if (WAIT_CYCLES > 15) begin : g_bad_wait
        $error("mem_responder: WAIT_CYCLES must be in 0..15");
    end
    if (AWIDTH < 1 || AWIDTH > 15) begin : g_bad_awidth
        $error("mem_responder: AWIDTH must be in 1..15");
    end

    typedef enum logic [2:0] {StIdle, StWait, StAccess, StResp, StDone} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              op_wr_q, op_wr_d;
    logic [15:0]       dread_q, dread_d;
    logic              read_en_q, read_en_d;
    logic              write_done_q, write_done_d;
    logic              busy_q, busy_d;
    logic              mem_we;
    logic              acc_err;

    // Not reset: contents are undefined after power-up.
    logic [15:0]       mem [Depth];

`ifdef MEM_BOUNDS_CHECK_EN
    logic err_q, err_d;
    logic mem_err_q, mem_err_d;
    assign acc_err = err_q;
`else
    // Upper address bits deliberately ignored: the array wraps.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[15:AWIDTH];
    assign acc_err        = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        op_wr_d      = op_wr_q;
        dread_d      = dread_q;
        read_en_d    = read_en_q;
        write_done_d = write_done_q;
        busy_d       = busy_q;
        mem_we       = 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
        err_d        = err_q;
        mem_err_d    = mem_err_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (bus.memRead || bus.memWrite) begin
                    addr_d  = bus.addr[AWIDTH-1:0];
                    wdata_d = bus.dWriteIn;
                    // Read wins when both requests are high.
                    op_wr_d = bus.memWrite && !bus.memRead;
                    busy_d  = 1'b1;
`ifdef MEM_BOUNDS_CHECK_EN
                    err_d   = |bus.addr[15:AWIDTH];
`endif
                    if (WAIT_CYCLES == 0) begin
                        state_d = StAccess;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (op_wr_q) begin
                    mem_we = !acc_err;
                end else begin
                    dread_d = acc_err ? 16'h0000 : mem[addr_q];
                end
                state_d = StResp;
            end
            StResp: begin
                read_en_d    = !op_wr_q;
                write_done_d = op_wr_q;
`ifdef MEM_BOUNDS_CHECK_EN
                mem_err_d    = err_q;
`endif
                state_d      = StDone;
            end
            StDone: begin
                read_en_d    = 1'b0;
                write_done_d = 1'b0;
                busy_d       = 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
                mem_err_d    = 1'b0;
`endif
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            addr_q       <= '0;
            wdata_q      <= 16'h0000;
            op_wr_q      <= 1'b0;
            dread_q      <= 16'h0000;
            read_en_q    <= 1'b0;
            write_done_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
            err_q        <= 1'b0;
            mem_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            op_wr_q      <= op_wr_d;
            dread_q      <= dread_d;
            read_en_q    <= read_en_d;
            write_done_q <= write_done_d;
            busy_q       <= busy_d;
`ifdef MEM_BOUNDS_CHECK_EN
            err_q        <= err_d;
            mem_err_q    <= mem_err_d;
`endif
        end
    end

    // Reset at the access edge aborts the write.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign bus.dReadOut  = dread_q;
    assign bus.readEn    = read_en_q;
    assign bus.writeDone = write_done_q;
    assign bus.busy      = busy_q;
`ifdef MEM_BOUNDS_CHECK_EN
    assign bus.memErr    = mem_err_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: self-checking bench for mem_responder.
// Three instances with WAIT_CYCLES = 2, 0 and 1 share clock and reset; a behavioural model
// (array contents, last read value, latency rule) supplies every expected value.

module tb_mem_responder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [15:0] req_addr [3];
    logic [15:0] req_wd   [3];
    logic        req_rd   [3];
    logic        req_wr   [3];
    logic [15:0] o_dr     [3];
    logic        o_ren    [3];
    logic        o_wd     [3];
    logic        o_busy   [3];
`ifdef MEM_BOUNDS_CHECK_EN
    logic        o_err    [3];
`endif

    mem_responder_if bus0 ();
    mem_responder_if bus1 ();
    mem_responder_if bus2 ();

    mem_responder #(.AWIDTH(8), .WAIT_CYCLES(2)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
    mem_responder #(.AWIDTH(8), .WAIT_CYCLES(0)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
    mem_responder #(.AWIDTH(8), .WAIT_CYCLES(1)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

    assign bus0.addr = req_addr[0];  assign bus0.dWriteIn = req_wd[0];
    assign bus0.memRead = req_rd[0]; assign bus0.memWrite = req_wr[0];
    assign bus1.addr = req_addr[1];  assign bus1.dWriteIn = req_wd[1];
    assign bus1.memRead = req_rd[1]; assign bus1.memWrite = req_wr[1];
    assign bus2.addr = req_addr[2];  assign bus2.dWriteIn = req_wd[2];
    assign bus2.memRead = req_rd[2]; assign bus2.memWrite = req_wr[2];

    assign o_dr[0] = bus0.dReadOut; assign o_ren[0] = bus0.readEn;
    assign o_wd[0] = bus0.writeDone; assign o_busy[0] = bus0.busy;
    assign o_dr[1] = bus1.dReadOut; assign o_ren[1] = bus1.readEn;
    assign o_wd[1] = bus1.writeDone; assign o_busy[1] = bus1.busy;
    assign o_dr[2] = bus2.dReadOut; assign o_ren[2] = bus2.readEn;
    assign o_wd[2] = bus2.writeDone; assign o_busy[2] = bus2.busy;
`ifdef MEM_BOUNDS_CHECK_EN
    assign o_err[0] = bus0.memErr; assign o_err[1] = bus1.memErr; assign o_err[2] = bus2.memErr;
`endif

    // Reference model
    logic [15:0] ref_mem [3][256];
    logic [15:0] ref_dr  [3];
    int          lat     [3];

    // Per-cycle observations, index i = samples after edge E0+i
    logic        obs_busy [32];
    logic        obs_ren  [32];
    logic        obs_wd   [32];
    logic        obs_err  [32];
    logic [15:0] obs_dr   [32];

    int n_checks = 0;
    int n_fail   = 0;

    // Drive one request (accept edge E0 = next posedge), drop it after E0, record ncyc samples.
    task automatic run_txn(input int k, input bit rd, input bit wr, input logic [15:0] a,
                           input logic [15:0] d, input int ncyc);
        @(negedge clk);
        req_addr[k] = a;
        req_wd[k]   = d;
        req_rd[k]   = rd;
        req_wr[k]   = wr;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            obs_busy[i] = o_busy[k];
            obs_ren[i]  = o_ren[k];
            obs_wd[i]   = o_wd[k];
            obs_dr[i]   = o_dr[k];
`ifdef MEM_BOUNDS_CHECK_EN
            obs_err[i]  = o_err[k];
`else
            obs_err[i]  = 1'b0;
`endif
            if (i == 0) begin
                req_rd[k] = 1'b0;
                req_wr[k] = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        logic [15:0] v5, v6;
        logic [18:0] got;
        int w = lat[0];
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            got = {o_busy[k], o_ren[k], o_wd[k], o_dr[k]};
            n_checks++;
            if (got !== 19'h0) begin
                n_fail++;
                $display("FAIL reset_init k=%0d got=%h exp=0", k, got);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) ref_dr[k] = 16'h0000;

        v5 = 16'($urandom);
        v6 = 16'($urandom);
        run_txn(0, 1'b0, 1'b1, 16'h0005, v5, w + 4);
        ref_mem[0][5] = v5;
        run_txn(0, 1'b0, 1'b1, 16'h0006, v6, w + 4);
        ref_mem[0][6] = v6;

        // Reset held two cycles while the write to 0x05 sits in WAIT
        @(negedge clk);
        req_addr[0] = 16'h0005;
        req_wd[0]   = ~v5;
        req_wr[0]   = 1'b1;
        @(posedge clk);
        #1;
        req_wr[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            got = {o_busy[0], o_ren[0], o_wd[0], o_dr[0]};
            n_checks++;
            if (got !== 19'h0) begin
                n_fail++;
                $display("FAIL reset_mid_wait got=%h exp=0", got);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) ref_dr[k] = 16'h0000;

        // Reset exactly at the access edge of a write to 0x06
        @(negedge clk);
        req_addr[0] = 16'h0006;
        req_wd[0]   = ~v6;
        req_wr[0]   = 1'b1;
        @(posedge clk);
        #1;
        req_wr[0] = 1'b0;
        repeat (w) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({o_busy[0], o_wd[0], o_ren[0]} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_abort_quiet i=%0d got=%b exp=000", i,
                         {o_busy[0], o_wd[0], o_ren[0]});
            end
        end

        run_txn(0, 1'b1, 1'b0, 16'h0005, 16'h0, w + 4);
        n_checks++;
        if (obs_dr[w + 1] !== ref_mem[0][5] || obs_ren[w + 2] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_wait_abort got=%h/%b exp=%h/1", obs_dr[w + 1], obs_ren[w + 2],
                     ref_mem[0][5]);
        end
        run_txn(0, 1'b1, 1'b0, 16'h0006, 16'h0, w + 4);
        n_checks++;
        if (obs_dr[w + 1] !== ref_mem[0][6]) begin
            n_fail++;
            $display("FAIL reset_access_abort got=%h exp=%h", obs_dr[w + 1], ref_mem[0][6]);
        end
        ref_dr[0] = ref_mem[0][6];
    endtask

    // Write then read pairs; checks busy/readEn/writeDone/dReadOut on every cycle.
    task automatic test_rw_timing(input int k, input logic [15:0] a0, input logic [15:0] d0,
                                  input int nrand);
        int w = lat[k];
        logic [15:0] a, d, oldv, newv;
        logic [18:0] got, exp;
        bit rd;
        for (int t = 0; t <= nrand; t++) begin
            a = (t == 0) ? a0 : 16'($urandom_range(0, 255));
            d = (t == 0) ? d0 : 16'($urandom);
            for (int op = 0; op < 2; op++) begin
                rd   = (op == 1);
                oldv = ref_dr[k];
                newv = rd ? ref_mem[k][a[7:0]] : oldv;
                run_txn(k, rd, !rd, a, d, w + 5);
                for (int i = 0; i < w + 5; i++) begin
                    exp = {(i <= w + 2), (rd && i == w + 2), (!rd && i == w + 2),
                           ((rd && i >= w + 1) ? newv : oldv)};
                    got = {obs_busy[i], obs_ren[i], obs_wd[i], obs_dr[i]};
                    n_checks++;
                    if (got !== exp) begin
                        n_fail++;
                        $display("FAIL rw_timing k=%0d t=%0d op=%0d i=%0d got=%h exp=%h",
                                 k, t, op, i, got, exp);
                    end
                end
                if (!rd) ref_mem[k][a[7:0]] = d;
                else     ref_dr[k] = newv;
            end
        end
    endtask

    task automatic test_simultaneous();
        int w = lat[0];
        run_txn(0, 1'b0, 1'b1, 16'h0020, 16'h00AA, w + 4);
        ref_mem[0][8'h20] = 16'h00AA;
        run_txn(0, 1'b1, 1'b1, 16'h0020, 16'h5555, w + 5);
        for (int i = 0; i < w + 5; i++) begin
            n_checks++;
            if (obs_wd[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL simul_no_writedone i=%0d got=%b exp=0", i, obs_wd[i]);
            end
        end
        n_checks++;
        if (obs_dr[w + 1] !== ref_mem[0][8'h20] || obs_ren[w + 2] !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_read got=%h/%b exp=%h/1", obs_dr[w + 1], obs_ren[w + 2],
                     ref_mem[0][8'h20]);
        end
        run_txn(0, 1'b1, 1'b0, 16'h0020, 16'h0, w + 4);
        n_checks++;
        if (obs_dr[w + 1] !== ref_mem[0][8'h20]) begin
            n_fail++;
            $display("FAIL simul_mem_kept got=%h exp=%h", obs_dr[w + 1], ref_mem[0][8'h20]);
        end
        ref_dr[0] = ref_mem[0][8'h20];
    endtask

    task automatic test_back_to_back();
        int w = lat[2];
        int acc [$];
        logic [15:0] a_a, a_b, v_a, v_b, exp_dr;
        bit exp_busy, exp_ren, dr_due;
        a_a = 16'($urandom_range(0, 127));
        a_b = a_a + 16'd128;
        v_a = 16'($urandom);
        v_b = ~v_a;
        run_txn(2, 1'b0, 1'b1, a_a, v_a, w + 4);
        ref_mem[2][a_a[7:0]] = v_a;
        run_txn(2, 1'b0, 1'b1, a_b, v_b, w + 4);
        ref_mem[2][a_b[7:0]] = v_b;

        // memRead held over edges 0..11; acceptances every w+4 edges while held
        for (int s = 0; s <= 11; s += w + 4) acc.push_back(s);

        @(negedge clk);
        req_addr[2] = a_a;
        req_rd[2]   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            obs_busy[i] = o_busy[2];
            obs_ren[i]  = o_ren[2];
            obs_dr[i]   = o_dr[2];
            if (i == 0)  req_addr[2] = a_b;
            if (i == 11) req_rd[2] = 1'b0;
        end

        for (int i = 0; i < 16; i++) begin
            exp_busy = 1'b0;
            exp_ren  = 1'b0;
            dr_due   = 1'b0;
            exp_dr   = 16'h0;
            foreach (acc[n]) begin
                if (i >= acc[n] && i <= acc[n] + w + 2) exp_busy = 1'b1;
                if (i == acc[n] + w + 2) exp_ren = 1'b1;
                if (i == acc[n] + w + 1) begin
                    dr_due = 1'b1;
                    exp_dr = (n == 0) ? ref_mem[2][a_a[7:0]] : ref_mem[2][a_b[7:0]];
                end
            end
            n_checks++;
            if ({obs_busy[i], obs_ren[i]} !== {exp_busy, exp_ren}) begin
                n_fail++;
                $display("FAIL b2b_strobe i=%0d got=%b%b exp=%b%b", i, obs_busy[i], obs_ren[i],
                         exp_busy, exp_ren);
            end
            if (dr_due) begin
                n_checks++;
                if (obs_dr[i] !== exp_dr) begin
                    n_fail++;
                    $display("FAIL b2b_data i=%0d got=%h exp=%h", i, obs_dr[i], exp_dr);
                end
                ref_dr[2] = exp_dr;
            end
        end
    endtask

    task automatic test_bounds();
        int w = lat[0];
        logic [15:0] v, exp_dr;
        v = 16'($urandom);
        run_txn(0, 1'b0, 1'b1, 16'h0012, v, w + 5);
        ref_mem[0][8'h12] = v;

        run_txn(0, 1'b1, 1'b0, 16'h0112, 16'h0, w + 5);
`ifdef MEM_BOUNDS_CHECK_EN
        exp_dr = 16'h0000;
        for (int i = 0; i < w + 5; i++) begin
            n_checks++;
            if (obs_err[i] !== (i == w + 2)) begin
                n_fail++;
                $display("FAIL bounds_read_err i=%0d got=%b exp=%b", i, obs_err[i], (i == w + 2));
            end
        end
`else
        exp_dr = ref_mem[0][8'h12];
`endif
        n_checks++;
        if (obs_dr[w + 1] !== exp_dr || obs_ren[w + 2] !== 1'b1) begin
            n_fail++;
            $display("FAIL bounds_read got=%h/%b exp=%h/1", obs_dr[w + 1], obs_ren[w + 2], exp_dr);
        end
        ref_dr[0] = exp_dr;

        run_txn(0, 1'b0, 1'b1, 16'h0112, ~v, w + 5);
`ifdef MEM_BOUNDS_CHECK_EN
        n_checks++;
        if ({obs_err[w + 2], obs_wd[w + 2]} !== 2'b11) begin
            n_fail++;
            $display("FAIL bounds_write_err got=%b%b exp=11", obs_err[w + 2], obs_wd[w + 2]);
        end
`else
        ref_mem[0][8'h12] = ~v;
`endif
        run_txn(0, 1'b1, 1'b0, 16'h0012, 16'h0, w + 5);
        n_checks++;
        if (obs_dr[w + 1] !== ref_mem[0][8'h12] || obs_err[w + 2] !== 1'b0) begin
            n_fail++;
            $display("FAIL bounds_wrap got=%h/%b exp=%h/0", obs_dr[w + 1], obs_err[w + 2],
                     ref_mem[0][8'h12]);
        end
        ref_dr[0] = ref_mem[0][8'h12];
    endtask

    initial begin
        lat[0] = 2;
        lat[1] = 0;
        lat[2] = 1;
        for (int k = 0; k < 3; k++) begin
            req_addr[k] = 16'h0;
            req_wd[k]   = 16'h0;
            req_rd[k]   = 1'b0;
            req_wr[k]   = 1'b0;
        end
        reset = 1'b1;

        test_reset();
        test_rw_timing(0, 16'h0012, 16'hBEEF, 5);
        test_rw_timing(1, 16'h0000, 16'h1234, 3);
        test_simultaneous();
        test_back_to_back();
        test_bounds();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
